// File: rtl/cache_ctrl_2way_if.sv
// Bundle of CPU request/response, per-way array control and pmem line-port
// signals that connect the 2-way cache controller to its environment.
interface cache_ctrl_2way_if #(
    parameter int CNT_W = 32
);
    logic             mem_read;
    logic             mem_write;
    logic             mem_resp;
    logic [1:0]       valid_in;
    logic [1:0]       dirty_in;
    logic [1:0]       tag_match;
    logic             lru_in;
    logic [1:0]       valid_load;
    logic [1:0]       dirty_load;
    logic             dirty_wdata;
    logic [1:0]       tag_load;
    logic [1:0]       data_fill;
    logic [1:0]       data_cpu_we;
    logic             lru_load;
    logic             lru_wdata;
    logic             way_sel;
    logic             addr_sel;
    logic             pmem_read;
    logic             pmem_write;
    logic             pmem_resp;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output mem_read, mem_write, valid_in, dirty_in, tag_match, lru_in, pmem_resp,
        input  mem_resp, valid_load, dirty_load, dirty_wdata, tag_load, data_fill,
               data_cpu_we, lru_load, lru_wdata, way_sel, addr_sel, pmem_read,
               pmem_write, hit_count, miss_count
    );

    modport slave (
        input  mem_read, mem_write, valid_in, dirty_in, tag_match, lru_in, pmem_resp,
        output mem_resp, valid_load, dirty_load, dirty_wdata, tag_load, data_fill,
               data_cpu_we, lru_load, lru_wdata, way_sel, addr_sel, pmem_read,
               pmem_write, hit_count, miss_count
    );
endinterface

// File: rtl/cache_ctrl_2way.sv
// Control FSM for a 2-way set-associative write-back L1 cache: hit handling,
// victim write-back, line fill and saturating hit/miss counters.
module cache_ctrl_2way #(
    parameter int CNT_W = 32
) (
    input logic              clk,
    input logic              rst,
    cache_ctrl_2way_if.slave bus
);
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CHECK     = 2'd1;
    localparam logic [1:0] ST_WRITEBACK = 2'd2;
    localparam logic [1:0] ST_FILL      = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state_r;
    logic [1:0]       next_s;
    logic             victim_r;
    logic             refill_r;
    logic [CNT_W-1:0] hit_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;

    logic req_s;
    logic hit_s;
    logic hit_way_s;
    logic victim_dirty_s;
    logic victim_load_s;
    logic hit_inc_s;
    logic miss_inc_s;
    logic refill_set_s;
    logic refill_clr_s;

    assign req_s          = bus.mem_read | bus.mem_write;
    assign hit_s          = |(bus.valid_in & bus.tag_match);
    assign hit_way_s      = bus.valid_in[1] & bus.tag_match[1];
    assign victim_dirty_s = bus.valid_in[bus.lru_in] & bus.dirty_in[bus.lru_in];

    assign bus.hit_count  = hit_cnt_r;
    assign bus.miss_count = miss_cnt_r;

    // Next-state and output decode; reset forces every output low so pmem requests drop at once
    always_comb begin
        next_s          = state_r;
        victim_load_s   = 1'b0;
        hit_inc_s       = 1'b0;
        miss_inc_s      = 1'b0;
        refill_set_s    = 1'b0;
        refill_clr_s    = 1'b0;
        bus.mem_resp    = 1'b0;
        bus.valid_load  = 2'b00;
        bus.dirty_load  = 2'b00;
        bus.dirty_wdata = 1'b0;
        bus.tag_load    = 2'b00;
        bus.data_fill   = 2'b00;
        bus.data_cpu_we = 2'b00;
        bus.lru_load    = 1'b0;
        bus.lru_wdata   = 1'b0;
        bus.way_sel     = 1'b0;
        bus.addr_sel    = 1'b0;
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        if (rst) begin
            next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        next_s       = ST_CHECK;
                        refill_clr_s = 1'b1;
                    end else begin
                        next_s = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (hit_s) begin
                        bus.mem_resp  = 1'b1;
                        bus.way_sel   = hit_way_s;
                        bus.lru_load  = 1'b1;
                        bus.lru_wdata = ~hit_way_s;
                        hit_inc_s     = ~refill_r;
                        next_s        = ST_IDLE;
                        // A simultaneous read+write is treated as a write
                        if (bus.mem_write) begin
                            bus.data_cpu_we[hit_way_s] = 1'b1;
                            bus.dirty_load[hit_way_s]  = 1'b1;
                            bus.dirty_wdata            = 1'b1;
                        end else begin
                            bus.dirty_wdata = 1'b0;
                        end
                    end else begin
                        victim_load_s = 1'b1;
                        miss_inc_s    = 1'b1;
                        next_s        = victim_dirty_s ? ST_WRITEBACK : ST_FILL;
                    end
                end
                ST_WRITEBACK: begin
                    bus.pmem_write = 1'b1;
                    bus.addr_sel   = 1'b1;
                    bus.way_sel    = victim_r;
                    next_s         = bus.pmem_resp ? ST_FILL : ST_WRITEBACK;
                end
                ST_FILL: begin
                    bus.pmem_read = 1'b1;
                    bus.addr_sel  = 1'b0;
                    if (bus.pmem_resp) begin
                        bus.data_fill[victim_r]  = 1'b1;
                        bus.tag_load[victim_r]   = 1'b1;
                        bus.valid_load[victim_r] = 1'b1;
                        bus.dirty_load[victim_r] = 1'b1;
                        bus.dirty_wdata          = 1'b0;
                        refill_set_s             = 1'b1;
                        next_s                   = ST_CHECK;
                    end else begin
                        next_s = ST_FILL;
                    end
                end
                default: begin
                    next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, victim, refill flag and saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            victim_r   <= 1'b0;
            refill_r   <= 1'b0;
            hit_cnt_r  <= {CNT_W{1'b0}};
            miss_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_s;
            if (victim_load_s) begin
                victim_r <= bus.lru_in;
            end
            if (refill_set_s) begin
                refill_r <= 1'b1;
            end else if (refill_clr_s) begin
                refill_r <= 1'b0;
            end
            if (hit_inc_s && (hit_cnt_r != CNT_MAX)) begin
                hit_cnt_r <= hit_cnt_r + CNT_ONE;
            end
            if (miss_inc_s && (miss_cnt_r != CNT_MAX)) begin
                miss_cnt_r <= miss_cnt_r + CNT_ONE;
            end
        end
    end
endmodule
